// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC residual block sequencer.
package cavlc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CT   = 3'd1,
    LV   = 3'd2,
    TZ   = 3'd3,
    RB   = 3'd4,
    FIN  = 3'd5
  } cavlc_state_e;

  localparam logic [4:0] MAX_COEFF_LUMA = 5'd16;
  localparam logic [4:0] MAX_COEFF_AC   = 5'd15;
  localparam logic [4:0] MAX_COEFF_CDC  = 5'd4;

  localparam int SHIFT_W_DEF = 5;

endpackage

// File: rtl/cavlc_block_ctrl_if.sv
// Block-level handshake plus the four stage decoder control/shift buses.
interface cavlc_block_ctrl_if
  import cavlc_pkg::*;
#(
  parameter int SHIFT_W = SHIFT_W_DEF
);
  logic               Start;
  logic [4:0]         MaxNumCoeff;
  logic               Busy;
  logic               Done;
  logic               Error;
  logic               CtEnable, LvEnable, TzEnable, RbEnable;
  logic               CtDone, LvDone, TzDone, RbDone;
  logic [4:0]         CtTotalCoeff;
  logic [1:0]         CtTrailingOnes;
  logic [3:0]         TzTotalZeros;
  logic [4:0]         TotalCoeff;
  logic [1:0]         TrailingOnes;
  logic [3:0]         ZerosLeft;
  logic [SHIFT_W-1:0] CtNumShift, LvNumShift, TzNumShift, RbNumShift;
  logic               CtShiftEn, LvShiftEn, TzShiftEn, RbShiftEn;
  logic [SHIFT_W-1:0] NumShift;
  logic               ShiftEn;

  // Sequencer side.
  modport master (
    input  Start, MaxNumCoeff,
    input  CtDone, LvDone, TzDone, RbDone,
    input  CtTotalCoeff, CtTrailingOnes, TzTotalZeros,
    input  CtNumShift, LvNumShift, TzNumShift, RbNumShift,
    input  CtShiftEn, LvShiftEn, TzShiftEn, RbShiftEn,
    output Busy, Done, Error,
    output CtEnable, LvEnable, TzEnable, RbEnable,
    output TotalCoeff, TrailingOnes, ZerosLeft,
    output NumShift, ShiftEn
  );

  // Parser and stage decoder side.
  modport slave (
    output Start, MaxNumCoeff,
    output CtDone, LvDone, TzDone, RbDone,
    output CtTotalCoeff, CtTrailingOnes, TzTotalZeros,
    output CtNumShift, LvNumShift, TzNumShift, RbNumShift,
    output CtShiftEn, LvShiftEn, TzShiftEn, RbShiftEn,
    input  Busy, Done, Error,
    input  CtEnable, LvEnable, TzEnable, RbEnable,
    input  TotalCoeff, TrailingOnes, ZerosLeft,
    input  NumShift, ShiftEn
  );
endinterface

// File: rtl/cavlc_shift_mux.sv
// Selects the active stage's shift request for the single bitstream shifter.
module cavlc_shift_mux
  import cavlc_pkg::*;
#(
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  cavlc_state_e       i_state,
  input  logic [SHIFT_W-1:0] i_ct_num,
  input  logic [SHIFT_W-1:0] i_lv_num,
  input  logic [SHIFT_W-1:0] i_tz_num,
  input  logic [SHIFT_W-1:0] i_rb_num,
  input  logic               i_ct_en,
  input  logic               i_lv_en,
  input  logic               i_tz_en,
  input  logic               i_rb_en,
  output logic [SHIFT_W-1:0] o_num,
  output logic               o_en
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_num = '0;
    o_en  = 1'b0;
    case (i_state)
      CT: begin o_num = i_ct_num; o_en = i_ct_en; end
      LV: begin o_num = i_lv_num; o_en = i_lv_en; end
      TZ: begin o_num = i_tz_num; o_en = i_tz_en; end
      RB: begin o_num = i_rb_num; o_en = i_rb_en; end
      default: ;
    endcase
  end

endmodule

// File: rtl/cavlc_block_ctrl.sv
// Per-4x4-block sequencer: runs coeff_token, level, total_zeros, run_before in
// order, skips stages with no coded syntax and aborts stuck stages via watchdog.
module cavlc_block_ctrl
  import cavlc_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input logic                Clk,
  input logic                nReset,
  cavlc_block_ctrl_if.master bus
);

  cavlc_state_e r_state, w_state_nxt;
  logic [4:0]   r_max;
  logic [4:0]   r_tc;
  logic [1:0]   r_t1;
  logic [3:0]   r_zl;
  logic         r_error;
  logic [7:0]   r_cnt;

  logic w_in_stage, w_stage_done, w_timeout, w_wd_fire, w_accept, w_ct_ovf;

  assign w_in_stage = (r_state == CT) || (r_state == LV) ||
                      (r_state == TZ) || (r_state == RB);
  assign w_timeout  = (r_cnt == 8'(TIMEOUT - 1));
  // A stage finishing on its last allowed cycle still completes normally.
  assign w_wd_fire  = w_in_stage && !w_stage_done && w_timeout;
  assign w_accept   = (r_state == IDLE) && bus.Start;
  assign w_ct_ovf   = (r_state == CT) && bus.CtDone && (bus.CtTotalCoeff > r_max);

  always_comb begin
    w_stage_done = 1'b0;
    w_state_nxt  = r_state;
    case (r_state)
      IDLE: if (bus.Start) w_state_nxt = CT;
      CT: begin
        w_stage_done = bus.CtDone;
        if (bus.CtDone) w_state_nxt = (bus.CtTotalCoeff == 5'd0) ? FIN : LV;
      end
      LV: begin
        w_stage_done = bus.LvDone;
        // An oversized TotalCoeff is treated as a full block: no total_zeros.
        if (bus.LvDone) w_state_nxt = (r_tc >= r_max) ? FIN : TZ;
      end
      TZ: begin
        w_stage_done = bus.TzDone;
        if (bus.TzDone)
          w_state_nxt = (bus.TzTotalZeros == 4'd0 || r_tc == 5'd1) ? FIN : RB;
      end
      RB: begin
        w_stage_done = bus.RbDone;
        if (bus.RbDone) w_state_nxt = FIN;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_wd_fire) w_state_nxt = FIN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != 8'hFF)    r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_max   <= '0;
      r_tc    <= '0;
      r_t1    <= '0;
      r_zl    <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) r_max <= bus.MaxNumCoeff;
      if (r_state == CT && bus.CtDone) begin
        r_tc <= bus.CtTotalCoeff;
        r_t1 <= bus.CtTrailingOnes;
      end
      if (r_state == TZ && bus.TzDone) r_zl <= bus.TzTotalZeros;
      if (w_accept)                    r_error <= 1'b0;
      else if (w_wd_fire || w_ct_ovf)  r_error <= 1'b1;
    end
  end

  assign bus.Busy         = (r_state != IDLE);
  assign bus.Done         = (r_state == FIN);
  assign bus.Error        = r_error;
  assign bus.CtEnable     = (r_state == CT);
  assign bus.LvEnable     = (r_state == LV);
  assign bus.TzEnable     = (r_state == TZ);
  assign bus.RbEnable     = (r_state == RB);
  assign bus.TotalCoeff   = r_tc;
  assign bus.TrailingOnes = r_t1;
  assign bus.ZerosLeft    = r_zl;

  cavlc_shift_mux #(.SHIFT_W(SHIFT_W)) u_shift_mux (
    .i_state  (r_state),
    .i_ct_num (bus.CtNumShift),
    .i_lv_num (bus.LvNumShift),
    .i_tz_num (bus.TzNumShift),
    .i_rb_num (bus.RbNumShift),
    .i_ct_en  (bus.CtShiftEn),
    .i_lv_en  (bus.LvShiftEn),
    .i_tz_en  (bus.TzShiftEn),
    .i_rb_en  (bus.RbShiftEn),
    .o_num    (bus.NumShift),
    .o_en     (bus.ShiftEn)
  );

endmodule

// File: tb/tb_cavlc_block_ctrl.sv
// Scoreboard bench for cavlc_block_ctrl: expected block results are queued at
// Start and compared when Done pulses; timing and routing are checked inline.
module tb_cavlc_block_ctrl;

  localparam int SHIFT_W = 5;

  logic Clk;
  logic nReset;

  cavlc_block_ctrl_if #(.SHIFT_W(SHIFT_W)) bus ();

  cavlc_block_ctrl #(.TIMEOUT(64), .SHIFT_W(SHIFT_W)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] mask;  // {RB,TZ,LV,CT} stages expected to be enabled
    logic       err;
    logic [4:0] tc;
    logic [1:0] t1;
    logic [3:0] zl;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] last_zl = 4'd0;

  // Fixed per-stage shift requests; TZ's enable is low to prove the enable is muxed.
  int   sh_num[4] = '{7, 3, 11, 20};
  logic sh_en[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic en_of(input int s);
    case (s)
      0:       return bus.CtEnable;
      1:       return bus.LvEnable;
      2:       return bus.TzEnable;
      default: return bus.RbEnable;
    endcase
  endfunction

  task automatic set_done(input int s, input logic v);
    case (s)
      0:       bus.CtDone = v;
      1:       bus.LvDone = v;
      2:       bus.TzDone = v;
      default: bus.RbDone = v;
    endcase
  endtask

  // Monitor: collects visited stages and checks each Done against the scoreboard.
  logic [3:0] mon_mask = '0;
  logic       mon_multi = 1'b0;
  logic       prev_done = 1'b0;

  always @(negedge Clk) begin
    if (!nReset) begin
      mon_mask  = '0;
      mon_multi = 1'b0;
      prev_done = 1'b0;
    end else begin
      mon_mask = mon_mask | {bus.RbEnable, bus.TzEnable, bus.LvEnable, bus.CtEnable};
      if ($countones({bus.RbEnable, bus.TzEnable, bus.LvEnable, bus.CtEnable}) > 1)
        mon_multi = 1'b1;
      if (bus.Done) begin
        check("done_width", 32'(prev_done), 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_stages", 32'(mon_mask), 32'(e.mask));
          check("sb_error", 32'(bus.Error), 32'(e.err));
          check("sb_total_coeff", 32'(bus.TotalCoeff), 32'(e.tc));
          check("sb_trailing_ones", 32'(bus.TrailingOnes), 32'(e.t1));
          check("sb_zeros_left", 32'(bus.ZerosLeft), 32'(e.zl));
          check("sb_onehot_enables", 32'(mon_multi), 0);
          check("sb_done_no_enable", 32'({bus.RbEnable, bus.TzEnable, bus.LvEnable, bus.CtEnable}), 0);
        end
        mon_mask  = '0;
        mon_multi = 1'b0;
      end
      prev_done = bus.Done;
    end
  end

  task automatic wait_en(input int s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (en_of(s)) begin
        ok = 1'b1;
        return;
      end
      @(negedge Clk);
    end
    check($sformatf("stage%0d_enable_timeout", s), 0, 1);
  endtask

  task automatic run_stage(input int s, input int dly, input int tc, input int t1,
                           input int tz, input bit last, input bit fin_start);
    bit ok;
    wait_en(s, ok);
    if (!ok) return;
    check($sformatf("stage%0d_num_shift", s), 32'(bus.NumShift), 32'(sh_num[s]));
    check($sformatf("stage%0d_shift_en", s), 32'(bus.ShiftEn), 32'(sh_en[s]));
    if (s >= 1) check($sformatf("stage%0d_total_coeff_held", s), 32'(bus.TotalCoeff), 32'(tc));
    if (s == 3) check("rb_zeros_left_held", 32'(bus.ZerosLeft), 32'(tz));
    repeat (dly) @(negedge Clk);
    bus.CtTotalCoeff   = 5'(tc);
    bus.CtTrailingOnes = 2'(t1);
    bus.TzTotalZeros   = 4'(tz);
    set_done(s, 1'b1);
    #1;
    check($sformatf("stage%0d_last_shift", s), 32'(bus.NumShift), 32'(sh_num[s]));
    @(negedge Clk);
    set_done(s, 1'b0);
    check($sformatf("stage%0d_exit", s), 32'(en_of(s)), 0);
    if (last) begin
      check($sformatf("stage%0d_done_latency", s), 32'(bus.Done), 1);
      if (fin_start) begin
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        check("fin_start_ignored", 32'(bus.Busy), 0);
      end
    end
  endtask

  task automatic start_block(input int mx);
    @(negedge Clk);
    bus.Start       = 1'b1;
    bus.MaxNumCoeff = 5'(mx);
    @(negedge Clk);
    bus.Start = 1'b0;
    check("start_busy", 32'(bus.Busy), 1);
    check("start_clears_error", 32'(bus.Error), 0);
  endtask

  task automatic do_block(input int mx, input int tc, input int t1, input int tz,
                          input bit hang, input bit fin_start);
    exp_t e;
    bit   ok;
    e.mask = 4'b0001;
    e.err  = 1'b0;
    e.tc   = 5'(tc);
    e.t1   = 2'(t1);
    e.zl   = last_zl;
    if (tc != 0) begin
      e.mask[1] = 1'b1;
      if (hang) e.err = 1'b1;
      else begin
        if (tc > mx) e.err = 1'b1;
        if (tc < mx) begin
          e.mask[2] = 1'b1;
          e.zl      = 4'(tz);
          if (tz != 0 && tc != 1) e.mask[3] = 1'b1;
        end
      end
    end
    last_zl = e.zl;
    sb.push_back(e);
    start_block(mx);
    run_stage(0, 2, tc, t1, tz, tc == 0, fin_start && tc == 0);
    if (tc != 0) begin
      if (hang) begin
        wait_en(1, ok);
        for (int k = 0; k < 64; k++) begin
          if (k == 63) begin
            check("wd_pre_error", 32'(bus.Error), 0);
            check("wd_pre_enable", 32'(bus.LvEnable), 1);
          end
          @(negedge Clk);
        end
        check("wd_error_set", 32'(bus.Error), 1);
        check("wd_done_pulse", 32'(bus.Done), 1);
      end else begin
        run_stage(1, 3, tc, t1, tz, !e.mask[2], fin_start && !e.mask[2]);
        if (e.mask[2]) run_stage(2, 1, tc, t1, tz, !e.mask[3], fin_start && !e.mask[3]);
        if (e.mask[3]) run_stage(3, 2, tc, t1, tz, 1'b1, fin_start);
      end
    end
    for (int i = 0; i < 10 && bus.Busy; i++) @(negedge Clk);
    check("busy_drop", 32'(bus.Busy), 0);
    check("idle_num_shift", 32'(bus.NumShift), 0);
    check("idle_shift_en", 32'(bus.ShiftEn), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.Busy), 0);
    check({tag, "_done"}, 32'(bus.Done), 0);
    check({tag, "_error"}, 32'(bus.Error), 0);
    check({tag, "_enables"}, 32'({bus.RbEnable, bus.TzEnable, bus.LvEnable, bus.CtEnable}), 0);
    check({tag, "_latched"}, 32'({bus.TotalCoeff, bus.TrailingOnes, bus.ZerosLeft}), 0);
    check({tag, "_shift"}, 32'({bus.NumShift, bus.ShiftEn}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    nReset           = 1'b0;
    bus.Start        = 1'b0;
    bus.MaxNumCoeff  = 5'd0;
    bus.CtDone       = 1'b0;
    bus.LvDone       = 1'b0;
    bus.TzDone       = 1'b0;
    bus.RbDone       = 1'b0;
    bus.CtTotalCoeff = 5'd0;
    bus.CtTrailingOnes = 2'd0;
    bus.TzTotalZeros = 4'd0;
    bus.CtNumShift   = 5'(sh_num[0]);
    bus.LvNumShift   = 5'(sh_num[1]);
    bus.TzNumShift   = 5'(sh_num[2]);
    bus.RbNumShift   = 5'(sh_num[3]);
    bus.CtShiftEn    = sh_en[0];
    bus.LvShiftEn    = sh_en[1];
    bus.TzShiftEn    = sh_en[2];
    bus.RbShiftEn    = sh_en[3];
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    nReset = 1'b1;
    repeat (2) @(negedge Clk);

    do_block(16, 0, 0, 0, 1'b0, 1'b0);   // empty block: CT only
    do_block(16, 3, 1, 2, 1'b0, 1'b0);   // full walk CT/LV/TZ/RB
    do_block(4,  4, 3, 0, 1'b0, 1'b0);   // chroma DC full: TZ/RB skipped
    do_block(16, 5, 2, 0, 1'b0, 1'b0);   // zero TotalZeros: RB skipped
    do_block(15, 1, 1, 7, 1'b0, 1'b0);   // single coeff: RB skipped
    do_block(4,  6, 3, 0, 1'b0, 1'b0);   // overflowing TotalCoeff: Error
    do_block(15, 2, 0, 3, 1'b0, 1'b1);   // Error cleared; Start in FIN ignored
    do_block(16, 3, 2, 0, 1'b1, 1'b0);   // LV watchdog
    do_block(16, 0, 0, 0, 1'b0, 1'b0);   // Error cleared after watchdog

    // Reset while total_zeros is active: immediate abort, no Done.
    start_block(16);
    run_stage(0, 1, 3, 1, 2, 1'b0, 1'b0);
    run_stage(1, 1, 3, 1, 2, 1'b0, 1'b0);
    wait_en(2, ok);
    nReset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge Clk);
    nReset  = 1'b1;
    last_zl = 4'd0;
    repeat (5) @(negedge Clk);
    check("post_reset_idle", 32'(bus.Busy), 0);

    do_block(16, 3, 0, 4, 1'b0, 1'b0);   // recovery after reset

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cavlc_block_ctrl.md
Name: cavlc_block_ctrl

Overview:
- Per-4x4-block sequencer for the CAVLC residual decoder.
- Runs the four stage decoders in fixed order: coeff_token, level decode, total_zeros, run_before.
- Owns the single bitstream shifter. Only the active stage's NumShift/ShiftEn reach it.
- Latches TotalCoeff/TrailingOnes for downstream stages, skips stages that carry no syntax, and flags stuck stages with a watchdog.

Parameters:
- TIMEOUT, 64, max cycles any one stage may stay active before Error.
- SHIFT_W, 5, width of shift-amount buses.

Ports:
- Clk  in  1  clock
- nReset  in  1  asynchronous, active-low reset
- Start  in  1  begin one block; sampled only in IDLE
- MaxNumCoeff  in  5  16 (luma 4x4), 15 (AC), 4 (chroma DC); sampled with Start
- Busy  out  1  high from accepted Start until Done cycle inclusive
- Done  out  1  one-cycle pulse, block complete
- Error  out  1  sticky watchdog flag; cleared by next accepted Start
- CtEnable / LvEnable / TzEnable / RbEnable  out  1 each  stage enables, at most one high
- CtDone / LvDone / TzDone / RbDone  in  1 each  stage-complete strobes, valid only while that stage is enabled
- CtTotalCoeff  in  5  from coeff_token, valid with CtDone
- CtTrailingOnes  in  2  from coeff_token, valid with CtDone
- TzTotalZeros  in  4  from total_zeros, valid with TzDone
- TotalCoeff  out  5  latched value fed to level/total_zeros/run_before
- TrailingOnes  out  2  latched value fed to level decode
- ZerosLeft  out  4  latched TotalZeros fed to run_before
- CtNumShift/LvNumShift/TzNumShift/RbNumShift  in  SHIFT_W each
- CtShiftEn/LvShiftEn/TzShiftEn/RbShiftEn  in  1 each
- NumShift  out  SHIFT_W  muxed shift amount to shifter
- ShiftEn  out  1  muxed shift enable

Behaviour:
- Reset values: state IDLE; all outputs 0 (Busy, Done, Error, all enables, TotalCoeff, TrailingOnes, ZerosLeft, NumShift, ShiftEn). Reset mid-block aborts immediately. No partial Done.
- FSM states: IDLE, CT, LV, TZ, RB, FIN.
- IDLE: on Start, latch MaxNumCoeff, clear Error, go CT.
- CT: CtEnable=1. On CtDone:
  - latch TotalCoeff/TrailingOnes.
  - TotalCoeff==0: go FIN.
  - otherwise: go LV.
- LV: LvEnable=1. On LvDone:
  - TotalCoeff==MaxNumCoeff: go FIN (total_zeros not coded).
  - otherwise: go TZ.
- TZ: TzEnable=1. On TzDone:
  - latch ZerosLeft=TzTotalZeros.
  - TotalZeros==0 or TotalCoeff==1: go FIN.
  - otherwise: go RB.
- RB: RbEnable=1. On RbDone, go FIN.
- FIN: Done=1 for one cycle, all enables 0, then IDLE.
- Enable drop: every stage enable is low for at least one cycle between blocks, so level decode's internal coefficient counter resets.
- Done strobes: registered transition. The stage's Done cycle is its last enabled cycle, and its final shift is still routed that cycle.
- Shift mux: combinational from the current state. NumShift/ShiftEn = active stage inputs in CT/LV/TZ/RB; 0 in IDLE/FIN. Inactive stages' shift inputs are ignored even if nonzero.
- Watchdog:
  - 8-bit cycle counter, cleared on every state change.
  - Counter reaching TIMEOUT in CT/LV/TZ/RB sets Error and forces FIN.
  - Done still pulses, so the upstream slice parser never hangs.
- Edge cases:
  - Start while Busy is ignored.
  - Start in the FIN cycle is ignored; Start may be reasserted the cycle after.
  - Done input of a non-active stage is ignored.
  - TotalCoeff > MaxNumCoeff from coeff_token: treated as ==MaxNumCoeff for the skip decision, and Error is set.
- Busy = (state != IDLE).

Decomposition:
- cavlc_pkg:
  - state enum cavlc_state_e {IDLE, CT, LV, TZ, RB, FIN}
  - constants MAX_COEFF_LUMA=16, MAX_COEFF_AC=15, MAX_COEFF_CDC=4
  - SHIFT_W default
- One sub-module: cavlc_shift_mux. Combinational 4:1 shift-request selector keyed by state; reusable by the top-level bitstream unit.

Test Plan:
- Start, MaxNumCoeff=16, CtDone with TotalCoeff=0 -> CT only, Done 1 cycle after CtDone, LvEnable never high.
- TotalCoeff=3, TrailingOnes=1, TzTotalZeros=2 -> CT, LV, TZ, RB visited in order; TotalCoeff=3 and ZerosLeft=2 held through RB; Done once.
- MaxNumCoeff=4, TotalCoeff=4 -> TZ/RB skipped, Done the cycle after LvDone.
- TzTotalZeros=0 with TotalCoeff=5 -> RB skipped.
- Shift routing: in LV drive CtShiftEn=1/CtNumShift=7 and LvNumShift=3 -> NumShift=3; IDLE -> NumShift=0, ShiftEn=0.
- Never assert LvDone, TIMEOUT=64 -> Error set 64 cycles after LV entry, Done pulses; next Start clears Error. nReset pulse in TZ -> all outputs 0 next edge, no Done.
